// File: rtl/qft_h_sequencer_if.sv
// Bundled start/done handshake, amplitude register-file ports and Hadamard-unit
// ports between qft_h_sequencer (master) and its environment (slave).
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif

interface qft_h_sequencer_if #(
  parameter int unsigned NQ = 3,
  parameter int unsigned TW = (NQ > 1) ? $clog2(NQ) : 1,
  parameter int unsigned W  = `TOTAL_WIDTH
);
  logic                 start;
  logic [TW-1:0]        target;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [NQ-1:0]        rd_addr_a;
  logic [NQ-1:0]        rd_addr_b;
  logic signed [W-1:0]  rd_a_r;
  logic signed [W-1:0]  rd_a_i;
  logic signed [W-1:0]  rd_b_r;
  logic signed [W-1:0]  rd_b_i;
  logic signed [W-1:0]  h_alpha_r;
  logic signed [W-1:0]  h_alpha_i;
  logic signed [W-1:0]  h_beta_r;
  logic signed [W-1:0]  h_beta_i;
  logic signed [W-1:0]  h_new_alpha_r;
  logic signed [W-1:0]  h_new_alpha_i;
  logic signed [W-1:0]  h_new_beta_r;
  logic signed [W-1:0]  h_new_beta_i;
  logic                 wr_en;
  logic [NQ-1:0]        wr_addr_a;
  logic [NQ-1:0]        wr_addr_b;
  logic signed [W-1:0]  wr_a_r;
  logic signed [W-1:0]  wr_a_i;
  logic signed [W-1:0]  wr_b_r;
  logic signed [W-1:0]  wr_b_i;

  modport master (
    input  start, target,
    input  rd_a_r, rd_a_i, rd_b_r, rd_b_i,
    input  h_new_alpha_r, h_new_alpha_i, h_new_beta_r, h_new_beta_i,
    output busy, done, err, rd_addr_a, rd_addr_b,
    output h_alpha_r, h_alpha_i, h_beta_r, h_beta_i,
    output wr_en, wr_addr_a, wr_addr_b, wr_a_r, wr_a_i, wr_b_r, wr_b_i
  );

  modport slave (
    output start, target,
    output rd_a_r, rd_a_i, rd_b_r, rd_b_i,
    output h_new_alpha_r, h_new_alpha_i, h_new_beta_r, h_new_beta_i,
    input  busy, done, err, rd_addr_a, rd_addr_b,
    input  h_alpha_r, h_alpha_i, h_beta_r, h_beta_i,
    input  wr_en, wr_addr_a, wr_addr_b, wr_a_r, wr_a_i, wr_b_r, wr_b_i
  );
endinterface

// File: rtl/qft_h_sequencer.sv
// Streams every amplitude pair of one target qubit through the pipelined Hadamard
// unit and writes results back. Optional QFT_HSEQ_PERF_EN adds a busy-cycle counter.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif

module qft_h_sequencer #(
  parameter int unsigned NQ    = 3,
  parameter int unsigned H_LAT = 4,
  parameter int unsigned TW    = (NQ > 1) ? $clog2(NQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  qft_h_sequencer_if.master  bus
`ifdef QFT_HSEQ_PERF_EN
  ,
  output logic [15:0]        perf_cycles
`endif
);
  localparam int unsigned KW = (NQ > 1) ? NQ - 1 : 1;
  localparam int unsigned P  = 32'd1 << (NQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [TW-1:0]   r_tgt;
  logic            r_err;
  logic [H_LAT-1:0] r_vld;
  logic [NQ-1:0]   r_pa [H_LAT];
  logic [NQ-1:0]   r_pb [H_LAT];

  logic            w_issue;
  logic            w_accept;
  logic            w_reject;
  logic            w_inner_vld;
  logic [NQ-1:0]   w_kx;
  logic [NQ-1:0]   w_mask;
  logic [NQ-1:0]   w_pa;
  logic [NQ-1:0]   w_pb;
  logic [NQ-1:0]   w_rd_a;
  logic [NQ-1:0]   w_rd_b;

  // Pair k -> addresses: insert a 0 at bit tgt, then set that bit for the partner
  assign w_kx   = NQ'(r_k);
  assign w_mask = (NQ'(1) << r_tgt) - NQ'(1);
  assign w_pa   = ((w_kx & ~w_mask) << 1) | (w_kx & w_mask);
  assign w_pb   = w_pa | (NQ'(1) << r_tgt);
  assign w_rd_a = w_issue ? w_pa : '0;
  assign w_rd_b = w_issue ? w_pb : '0;

  // Any entry still in flight other than the one at the write-back tail
  always_comb begin
    w_inner_vld = 1'b0;
    for (int i = 0; i < int'(H_LAT) - 1; i++) w_inner_vld = w_inner_vld | r_vld[i];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (32'(bus.target) < NQ) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = S_FIN;
          end
        end
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        if (r_k == KW'(P - 1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (!w_inner_vld) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operation context and the in-flight address pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k   <= '0;
      r_tgt <= '0;
      r_err <= 1'b0;
      r_vld <= '0;
      for (int i = 0; i < int'(H_LAT); i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_tgt <= bus.target;
        r_k   <= '0;
        r_err <= 1'b0;
      end else if (w_reject) begin
        r_err <= 1'b1;
      end else if (w_issue) begin
        r_k <= r_k + KW'(1);
      end
      r_vld[0] <= w_issue;
      r_pa[0]  <= w_rd_a;
      r_pb[0]  <= w_rd_b;
      for (int i = 1; i < int'(H_LAT); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_pa[i]  <= r_pa[i-1];
        r_pb[i]  <= r_pb[i-1];
      end
    end
  end

  assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign bus.done      = (r_state == S_FIN);
  assign bus.err       = (r_state == S_FIN) && r_err;
  assign bus.rd_addr_a = w_rd_a;
  assign bus.rd_addr_b = w_rd_b;
  assign bus.h_alpha_r = w_issue ? bus.rd_a_r : '0;
  assign bus.h_alpha_i = w_issue ? bus.rd_a_i : '0;
  assign bus.h_beta_r  = w_issue ? bus.rd_b_r : '0;
  assign bus.h_beta_i  = w_issue ? bus.rd_b_i : '0;
  assign bus.wr_en     = r_vld[H_LAT-1];
  assign bus.wr_addr_a = r_pa[H_LAT-1];
  assign bus.wr_addr_b = r_pb[H_LAT-1];
  assign bus.wr_a_r    = bus.h_new_alpha_r;
  assign bus.wr_a_i    = bus.h_new_alpha_i;
  assign bus.wr_b_r    = bus.h_new_beta_r;
  assign bus.wr_b_i    = bus.h_new_beta_i;

`ifdef QFT_HSEQ_PERF_EN
  logic [15:0] r_perf_cycles;

  // Busy cycles of the latest operation; cleared by any start seen in IDLE
  always_ff @(posedge clk) begin
    if (rst)                                   r_perf_cycles <= '0;
    else if (w_accept || w_reject)             r_perf_cycles <= '0;
    else if (bus.busy && r_perf_cycles != 16'hFFFF) r_perf_cycles <= r_perf_cycles + 16'd1;
  end

  assign perf_cycles = r_perf_cycles;
`endif
endmodule

// File: tb/tb_qft_h_sequencer.sv
// Self-checking bench for qft_h_sequencer: register file and 4-stage Hadamard unit
// models, directed and random gate applications compared against a state-vector model.
module tb_qft_h_sequencer;
  localparam int NQ    = 3;
  localparam int H_LAT = 4;
  localparam int P     = 4;
  localparam int N     = 8;

  logic clk = 1'b0;
  logic rst;
  logic load;
  always #5 clk = ~clk;

  qft_h_sequencer_if #(.NQ(NQ)) bus ();

`ifdef QFT_HSEQ_PERF_EN
  logic [15:0] perf_cycles;
  int          perf_last;
`endif

  qft_h_sequencer #(.NQ(NQ), .H_LAT(H_LAT)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef QFT_HSEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  logic signed [7:0] mem_r [N];
  logic signed [7:0] mem_i [N];
  logic signed [7:0] init_r [N];
  logic signed [7:0] init_i [N];
  logic signed [7:0] exp_r [N];
  logic signed [7:0] exp_i [N];

  // Hadamard arithmetic: (a +/- b) * 181/256, i.e. times ~1/sqrt(2)
  function automatic logic signed [7:0] hf(input logic signed [7:0] a, input logic signed [7:0] b,
                                           input bit sub);
    int s;
    s = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    return 8'((s * 181) >>> 8);
  endfunction

  // Amplitude register file: combinational read, write on strobe
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= init_r[i];
        mem_i[i] <= init_i[i];
      end
    end else if (bus.wr_en) begin
      mem_r[bus.wr_addr_a] <= bus.wr_a_r;
      mem_i[bus.wr_addr_a] <= bus.wr_a_i;
      mem_r[bus.wr_addr_b] <= bus.wr_b_r;
      mem_i[bus.wr_addr_b] <= bus.wr_b_i;
    end
  end

  assign bus.rd_a_r = mem_r[bus.rd_addr_a];
  assign bus.rd_a_i = mem_i[bus.rd_addr_a];
  assign bus.rd_b_r = mem_r[bus.rd_addr_b];
  assign bus.rd_b_i = mem_i[bus.rd_addr_b];

  // Hadamard unit: H_LAT clocks from operand sample to result
  logic signed [7:0] hp_ar [H_LAT];
  logic signed [7:0] hp_ai [H_LAT];
  logic signed [7:0] hp_br [H_LAT];
  logic signed [7:0] hp_bi [H_LAT];
  always_ff @(posedge clk) begin
    hp_ar[0] <= hf(bus.h_alpha_r, bus.h_beta_r, 1'b0);
    hp_ai[0] <= hf(bus.h_alpha_i, bus.h_beta_i, 1'b0);
    hp_br[0] <= hf(bus.h_alpha_r, bus.h_beta_r, 1'b1);
    hp_bi[0] <= hf(bus.h_alpha_i, bus.h_beta_i, 1'b1);
    for (int i = 1; i < H_LAT; i++) begin
      hp_ar[i] <= hp_ar[i-1];
      hp_ai[i] <= hp_ai[i-1];
      hp_br[i] <= hp_br[i-1];
      hp_bi[i] <= hp_bi[i-1];
    end
  end
  assign bus.h_new_alpha_r = hp_ar[H_LAT-1];
  assign bus.h_new_alpha_i = hp_ai[H_LAT-1];
  assign bus.h_new_beta_r  = hp_br[H_LAT-1];
  assign bus.h_new_beta_i  = hp_bi[H_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int iss_c[$], iss_a[$], iss_b[$];
  int wr_c[$], wr_a[$], wr_b[$];
  int done_c[$], busy_c[$];
  int err_cnt, err_bad, idle_bad;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic load_mem(input bit rnd);
    for (int i = 0; i < N; i++) begin
      init_r[i] = rnd ? 8'(int'($urandom_range(80)) - 40) : 8'sd0;
      init_i[i] = rnd ? 8'(int'($urandom_range(80)) - 40) : 8'sd0;
    end
    if (!rnd) init_r[0] = 8'sd16;
    for (int i = 0; i < N; i++) begin
      exp_r[i] = init_r[i];
      exp_i[i] = init_i[i];
    end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // State-vector model of H on qubit t
  task automatic model_h(input int t);
    logic signed [7:0] ar, ai, br, bi;
    for (int i = 0; i < N; i++) begin
      if (((i >> t) & 1) == 0) begin
        ar = exp_r[i]; ai = exp_i[i];
        br = exp_r[i | (1 << t)]; bi = exp_i[i | (1 << t)];
        exp_r[i] = hf(ar, br, 1'b0);
        exp_i[i] = hf(ai, bi, 1'b0);
        exp_r[i | (1 << t)] = hf(ar, br, 1'b1);
        exp_i[i | (1 << t)] = hf(ai, bi, 1'b1);
      end
    end
  endtask

  // Start one operation at edge 0, then observe cycles 1..ncyc at mid-cycle
  task automatic run_op(input int t, input int inj_a, input int inj_b, input int rst_cyc,
                        input int ncyc);
    iss_c.delete(); iss_a.delete(); iss_b.delete();
    wr_c.delete(); wr_a.delete(); wr_b.delete();
    done_c.delete(); busy_c.delete();
    err_cnt = 0; err_bad = 0; idle_bad = 0;
    bus.target = 2'(t);
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.rd_addr_b != 0) begin
        iss_c.push_back(c); iss_a.push_back(int'(bus.rd_addr_a)); iss_b.push_back(int'(bus.rd_addr_b));
      end else if (bus.rd_addr_a != 0 || bus.h_alpha_r != 0 || bus.h_alpha_i != 0 ||
                   bus.h_beta_r != 0 || bus.h_beta_i != 0) begin
        idle_bad++;
      end
      if (bus.wr_en) begin
        wr_c.push_back(c); wr_a.push_back(int'(bus.wr_addr_a)); wr_b.push_back(int'(bus.wr_addr_b));
      end
      if (bus.busy) busy_c.push_back(c);
      if (bus.done) done_c.push_back(c);
      if (bus.err) begin
        err_cnt++;
        if (!bus.done) err_bad++;
      end
      bus.start = (c == inj_a) || (c == inj_b);
      rst       = (c == rst_cyc);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
`ifdef QFT_HSEQ_PERF_EN
    perf_last = int'(perf_cycles);
`endif
  endtask

  task automatic check_mem(input string nm);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.mem_r%0d", nm, i), int'(mem_r[i]), int'(exp_r[i]));
      chk($sformatf("%s.mem_i%0d", nm, i), int'(mem_i[i]), int'(exp_i[i]));
    end
  endtask

  task automatic check_norm(input int t, input string nm);
    int ea[$], eb[$];
    for (int i = 0; i < N; i++)
      if (((i >> t) & 1) == 0) begin
        ea.push_back(i);
        eb.push_back(i | (1 << t));
      end
    chk({nm, ".n_issue"}, iss_c.size(), P);
    chk({nm, ".n_write"}, wr_c.size(), P);
    for (int k = 0; k < P; k++) begin
      if (k < iss_c.size()) begin
        chk($sformatf("%s.iss_cyc%0d", nm, k), iss_c[k], 1 + k);
        chk($sformatf("%s.iss_a%0d", nm, k), iss_a[k], ea[k]);
        chk($sformatf("%s.iss_b%0d", nm, k), iss_b[k], eb[k]);
      end
      if (k < wr_c.size()) begin
        chk($sformatf("%s.wr_cyc%0d", nm, k), wr_c[k], 1 + k + H_LAT);
        chk($sformatf("%s.wr_a%0d", nm, k), wr_a[k], ea[k]);
        chk($sformatf("%s.wr_b%0d", nm, k), wr_b[k], eb[k]);
      end
    end
    chk({nm, ".n_done"}, done_c.size(), 1);
    if (done_c.size() > 0) chk({nm, ".done_cyc"}, done_c[0], P + H_LAT + 1);
    chk({nm, ".n_err"}, err_cnt, 0);
    chk({nm, ".n_busy"}, busy_c.size(), P + H_LAT);
    if (busy_c.size() > 0) begin
      chk({nm, ".busy_first"}, busy_c[0], 1);
      chk({nm, ".busy_last"}, busy_c[busy_c.size()-1], P + H_LAT);
    end
    chk({nm, ".idle_outputs"}, idle_bad, 0);
`ifdef QFT_HSEQ_PERF_EN
    chk({nm, ".perf"}, perf_last, P + H_LAT);
`endif
    model_h(t);
    check_mem(nm);
  endtask

  task automatic check_err(input string nm);
    chk({nm, ".n_done"}, done_c.size(), 1);
    if (done_c.size() > 0) chk({nm, ".done_cyc"}, done_c[0], 1);
    chk({nm, ".n_err"}, err_cnt, 1);
    chk({nm, ".err_no_done"}, err_bad, 0);
    chk({nm, ".n_busy"}, busy_c.size(), 0);
    chk({nm, ".n_write"}, wr_c.size(), 0);
    chk({nm, ".n_issue"}, iss_c.size(), 0);
`ifdef QFT_HSEQ_PERF_EN
    chk({nm, ".perf"}, perf_last, 0);
`endif
    check_mem(nm);
  endtask

  initial begin
    int t;
    rst = 1'b1; load = 1'b0;
    bus.start = 1'b0; bus.target = '0;
    for (int i = 0; i < N; i++) begin init_r[i] = '0; init_i[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.done", int'(bus.done), 0);
    chk("rst.err", int'(bus.err), 0);
    chk("rst.wr_en", int'(bus.wr_en), 0);
    chk("rst.rd_addr_b", int'(bus.rd_addr_b), 0);
    chk("rst.wr_addr_b", int'(bus.wr_addr_b), 0);
    chk("rst.h_alpha_r", int'(bus.h_alpha_r), 0);
`ifdef QFT_HSEQ_PERF_EN
    chk("rst.perf", int'(perf_cycles), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Basis state |0> on qubit 0
    load_mem(1'b0);
    run_op(0, -1, -1, -1, 12);
    chk("dir.mem_r0_is_11", int'(mem_r[0]), 11);
    chk("dir.mem_r1_is_11", int'(mem_r[1]), 11);
    check_norm(0, "dir_t0");

    load_mem(1'b1);
    run_op(2, -1, -1, -1, 12);
    check_norm(2, "t2");

    load_mem(1'b1);
    run_op(3, -1, -1, -1, 6);
    check_err("t3_err");

    // start during the operation and in the done cycle must be ignored
    load_mem(1'b1);
    run_op(1, 3, 9, -1, 14);
    check_norm(1, "ign_start");

    // Reset mid-operation discards all in-flight pairs
    load_mem(1'b1);
    run_op(1, -1, -1, 3, 12);
    chk("rst_mid.n_write", wr_c.size(), 0);
    chk("rst_mid.n_busy", busy_c.size(), 3);
    chk("rst_mid.n_done", done_c.size(), 0);
`ifdef QFT_HSEQ_PERF_EN
    chk("rst_mid.perf", perf_last, 0);
`endif
    check_mem("rst_mid");
    run_op(1, -1, -1, -1, 12);
    check_norm(1, "after_rst");

    for (int r = 0; r < 6; r++) begin
      t = int'($urandom_range(3));
      load_mem(1'b1);
      run_op(t, -1, -1, -1, 12);
      if (t < NQ) check_norm(t, $sformatf("rnd%0d_t%0d", r, t));
      else        check_err($sformatf("rnd%0d_err", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qft_h_sequencer.md
# qft_h_sequencer

Sequencer that applies one Hadamard gate to a chosen target qubit of an NQ-qubit state vector. It walks every amplitude pair (i, i | 2^target) of an external amplitude register file and streams one pair per clock into the 4-stage pipelined Hadamard unit. It tracks the in-flight pairs and writes each result pair back to the register file. It sits between the QFT top-level controller (start/done handshake) and the shared Hadamard datapath.

## Interface
Parameters:
- NQ, 3, number of qubits; state vector holds 2^NQ amplitudes.
- H_LAT, 4, Hadamard unit latency in clocks (input sampled to output valid).
- TW, $clog2(NQ) (minimum 1), width of the target-qubit index.

Ports (W = `TOTAL_WIDTH, signed S3.4):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one gate application; sampled only in IDLE.
- target  in  TW  target qubit index; captured with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, when target >= NQ.
- rd_addr_a, rd_addr_b  out  NQ  amplitude pair read addresses; read data is combinational, same cycle.
- rd_a_r, rd_a_i, rd_b_r, rd_b_i  in  W  amplitude data for rd_addr_a/b.
- h_alpha_r, h_alpha_i, h_beta_r, h_beta_i  out  W  operands to the Hadamard unit.
- h_new_alpha_r, h_new_alpha_i, h_new_beta_r, h_new_beta_i  in  W  Hadamard unit results.
- wr_en  out  1  write-back strobe for both addresses.
- wr_addr_a, wr_addr_b  out  NQ  write-back addresses.
- wr_a_r, wr_a_i, wr_b_r, wr_b_i  out  W  write-back data.

## Operation
- P = 2^(NQ-1) pairs. For pair index k (NQ-1 bits), addr_a = k with a 0 bit inserted at bit position tgt; addr_b = addr_a | (1 << tgt).
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 with target < NQ captures tgt, clears k, and goes to ISSUE.
  - IDLE: start=1 with target >= NQ goes to FIN with the error flag set; no issue and no write occurs.
  - ISSUE: issues pair k each cycle and increments k. After k = P-1 it goes to DRAIN.
  - DRAIN: waits until the valid pipe is empty, then goes to FIN.
  - FIN: done=1 (err=1 if flagged) for one cycle, then returns to IDLE.
- Issue cycle: rd_addr_a/b = addresses of pair k, and h_alpha = rd_a, h_beta = rd_b.
- Non-issue cycles: h_* = 0 and rd_addr_* = 0.
- In-flight tracking: an H_LAT-deep shift register holds {valid, addr_a, addr_b}. An entry is pushed on every issue cycle; the tail drives wr_en and wr_addr_*.
- Write data: wr_a = h_new_alpha and wr_b = h_new_beta, passed through combinationally. They are don't-care when wr_en=0.
- No arithmetic in this block. Pairs are disjoint, so there is no read-after-write hazard within one gate.
- start while busy is ignored. start is also ignored in FIN, including a start arriving in the same cycle as done.
- Reset (rst=1 at an edge) in any state:
  - FSM returns to IDLE; k, tgt, and all valid bits clear.
  - Nothing issued before the reset is written back, even though the Hadamard unit still holds the data.

## Timing
- Reset values: busy=0, done=0, err=0, wr_en=0, all address and h_* outputs 0.
- The edge that samples start is edge 0; cycle n is the period after edge n.
- Pair k is issued in cycle 1+k and written (wr_en=1) in cycle 1+k+H_LAT.
- Write-backs are back-to-back in cycles 1+H_LAT .. P+H_LAT.
- done pulses in cycle P+H_LAT+1, and busy is 0 in that same cycle. busy is 1 in cycles 1 .. P+H_LAT.
- Error path: done=err=1 in cycle 1, and busy stays 0.
- Earliest next start is sampled at the edge ending the done cycle +1, i.e. while back in IDLE.

## Configuration
- QFT_HSEQ_PERF_EN defined: adds output perf_cycles (16 bits, reset 0).
  - It counts busy cycles of the current operation, saturating at 16'hFFFF.
  - The count holds from done until the next accepted start, which clears it to 0.
  - Expected value: P+H_LAT per valid operation, and 0 for an error operation.
- QFT_HSEQ_PERF_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- NQ=3, target=0, regfile amplitudes all zero except addr0 real = 16 (1.0):
  - issue order (0,1),(2,3),(4,5),(6,7);
  - writes in cycles 5..8; addr0 = addr1 real = 11, all others 0;
  - done in cycle 9, busy high in cycles 1..8.
- target=2: address pairs are (0,4),(1,5),(2,6),(3,7) in that order; wr_addr_* match the issue order delayed by 4 cycles.
- target=3 (invalid for NQ=3): done=err=1 in cycle 1, wr_en never asserted, busy never asserted.
- start pulsed in cycles 3 and 9 during an operation: both ignored; exactly 4 writes occur and exactly one done pulse.
- rst asserted in cycle 3 (two pairs issued): the next cycle has busy=0 and wr_en=0, and no wr_en occurs during the following 8 cycles. A fresh start then completes normally with 4 writes.
- QFT_HSEQ_PERF_EN: perf_cycles = 8 after a valid operation and 0 after an error operation.
